// File: rtl/sse_frame_sequencer_if.sv
// Handshake bundle between the SSE frame sequencer and its neighbours.
//   cmd_*        : host command byte (bit7 = camera source, bits[6:0] = SSE select)
//   cam_*        : camera pixel stream, cam_sync marks the first pixel of a frame
//   host_*       : host image FIFO pixels (first-word fall-through)
//   sse_select_* : SSE select register load
//   sse_in_*     : SSE image input
//   sse_out_fire : SSE output handshake, one per produced pixel
// Modport master is the sequencer side, slave is the environment side.
interface sse_frame_sequencer_if;
    localparam int unsigned PIX_W = 24;
    localparam int unsigned CMD_W = 8;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [CMD_W-1:0] cmd_bits;
    logic             cam_valid;
    logic             cam_ready;
    logic [PIX_W-1:0] cam_bits;
    logic             cam_sync;
    logic             host_valid;
    logic             host_ready;
    logic [PIX_W-1:0] host_bits;
    logic             sse_select_valid;
    logic             sse_select_ready;
    logic [CMD_W-1:0] sse_select_bits;
    logic             sse_in_valid;
    logic             sse_in_ready;
    logic [PIX_W-1:0] sse_in_bits;
    logic             sse_out_fire;

    modport master (
        input  cmd_valid, cmd_bits,
        input  cam_valid, cam_bits, cam_sync,
        input  host_valid, host_bits,
        input  sse_select_ready, sse_in_ready, sse_out_fire,
        output cmd_ready, cam_ready, host_ready,
        output sse_select_valid, sse_select_bits,
        output sse_in_valid, sse_in_bits
    );

    modport slave (
        output cmd_valid, cmd_bits,
        output cam_valid, cam_bits, cam_sync,
        output host_valid, host_bits,
        output sse_select_ready, sse_in_ready, sse_out_fire,
        input  cmd_ready, cam_ready, host_ready,
        input  sse_select_valid, sse_select_bits,
        input  sse_in_valid, sse_in_bits
    );
endinterface

// File: rtl/sse_frame_sequencer.sv
// Frame-level controller for the ScaleSpaceExtrema datapath.
// Accepts one command byte, loads the SSE select register, chooses camera or
// host pixels, forwards exactly one frame into SSE, counts output pixels and
// flags end-of-frame for the host read channel.
// Ports:
//   clk, reset_n : bus clock, asynchronous active-low reset
//   abort        : synchronous return to IDLE
//   bus          : command / camera / host / SSE handshakes (master side)
//   busy         : state is not IDLE
//   frame_done   : one-cycle pulse when the frame completes
//   out_eof      : end-of-frame level for the host read channel
module sse_frame_sequencer #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned CNT_W = 19
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  abort,
    sse_frame_sequencer_if.master bus,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  out_eof
);
    localparam int unsigned FRAME_PIX = IMG_W * IMG_H;
    localparam logic [CNT_W-1:0] LAST_PIX = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0] FULL_PIX = CNT_W'(FRAME_PIX);

    typedef enum logic [2:0] {
        S_IDLE, S_SELECT, S_SYNC, S_STREAM, S_DRAIN, S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic             src_q, src_d;
    logic [6:0]       sel_q, sel_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic             out_eof_q, out_eof_d;
    logic             in_valid_c;
    logic             in_fire_c;
    logic             out_full_c;
    logic             cam_sync_c;

    // State and datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            src_q     <= 1'b0;
            sel_q     <= '0;
            in_cnt_q  <= '0;
            out_cnt_q <= '0;
            out_eof_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            src_q     <= src_d;
            sel_q     <= sel_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
            out_eof_q <= out_eof_d;
        end
    end

    // Next state, counters, control decode and pixel mux
    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        sel_d     = sel_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        out_eof_d = out_eof_q;

        bus.cmd_ready        = (state_q == S_IDLE);
        bus.sse_select_valid = (state_q == S_SELECT);
        bus.sse_select_bits  = {1'b0, sel_q};
        bus.sse_in_valid     = 1'b0;
        bus.sse_in_bits      = '0;
        bus.cam_ready        = 1'b0;
        bus.host_ready       = 1'b0;
        busy                 = (state_q != S_IDLE);
        frame_done           = (state_q == S_DONE);
        out_eof              = out_eof_q;

        in_valid_c = 1'b0;
        in_fire_c  = 1'b0;
        cam_sync_c = bus.cam_valid & bus.cam_sync;
        // Output count is complete now or completes with this cycle's fire
        out_full_c = (out_cnt_q == FULL_PIX) ||
                     ((out_cnt_q == LAST_PIX) && bus.sse_out_fire);

        // Output pixels only count while the frame is in flight
        if ((state_q == S_STREAM || state_q == S_DRAIN) &&
            bus.sse_out_fire && (out_cnt_q != FULL_PIX)) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    src_d     = bus.cmd_bits[7];
                    sel_d     = bus.cmd_bits[6:0];
                    out_eof_d = 1'b0;
                    in_cnt_d  = '0;
                    out_cnt_d = '0;
                    state_d   = S_SELECT;
                end
            end
            S_SELECT: begin
                if (bus.sse_select_ready) begin
                    state_d = src_q ? S_SYNC : S_STREAM;
                end
            end
            S_SYNC: begin
                // Drop unsynchronised pixels; the sync pixel stays for STREAM
                bus.cam_ready = !cam_sync_c;
                if (cam_sync_c) begin
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                if (src_q) begin
                    in_valid_c      = bus.cam_valid;
                    bus.sse_in_bits = bus.cam_bits;
                    bus.cam_ready   = bus.sse_in_ready;
                end else begin
                    in_valid_c      = bus.host_valid;
                    bus.sse_in_bits = bus.host_bits;
                    bus.host_ready  = bus.sse_in_ready;
                end
                bus.sse_in_valid = in_valid_c;
                in_fire_c        = in_valid_c & bus.sse_in_ready;
                if (in_fire_c) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    if (in_cnt_q == LAST_PIX) begin
                        state_d = out_full_c ? S_DONE : S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (out_full_c) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                out_eof_d = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort wins over every transition; bus handshakes this cycle are not counted
        if (abort) begin
            state_d   = S_IDLE;
            src_d     = src_q;
            sel_d     = sel_q;
            in_cnt_d  = '0;
            out_cnt_d = '0;
            out_eof_d = 1'b0;
        end
    end
endmodule

// File: tb/tb_sse_frame_sequencer.sv
// Randomised frame-level bench for sse_frame_sequencer (4x2 frames).
module tb_sse_frame_sequencer;
    localparam int unsigned IMG_W = 4;
    localparam int unsigned IMG_H = 2;
    localparam int unsigned CNT_W = 4;
    localparam int FRAME   = int'(IMG_W * IMG_H);
    localparam int MAX_CYC = 400;

    logic clk = 1'b0;
    logic reset_n;
    logic abort;
    logic busy;
    logic frame_done;
    logic out_eof;

    int checks   = 0;
    int failures = 0;

    sse_frame_sequencer_if bus ();

    sse_frame_sequencer #(
        .IMG_W(IMG_W),
        .IMG_H(IMG_H),
        .CNT_W(CNT_W)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .abort     (abort),
        .bus       (bus),
        .busy      (busy),
        .frame_done(frame_done),
        .out_eof   (out_eof)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        abort                = 1'b0;
        bus.cmd_valid        = 1'b0;
        bus.cmd_bits         = '0;
        bus.cam_valid        = 1'b0;
        bus.cam_bits         = '0;
        bus.cam_sync         = 1'b0;
        bus.host_valid       = 1'b0;
        bus.host_bits        = '0;
        bus.sse_select_ready = 1'b0;
        bus.sse_in_ready     = 1'b0;
        bus.sse_out_fire     = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_cmd_ready"},    32'(bus.cmd_ready), 32'd1);
        check_eq({tag, "_busy"},         32'(busy), 32'd0);
        check_eq({tag, "_frame_done"},   32'(frame_done), 32'd0);
        check_eq({tag, "_out_eof"},      32'(out_eof), 32'd0);
        check_eq({tag, "_select_valid"}, 32'(bus.sse_select_valid), 32'd0);
        check_eq({tag, "_in_valid"},     32'(bus.sse_in_valid), 32'd0);
        check_eq({tag, "_cam_ready"},    32'(bus.cam_ready), 32'd0);
        check_eq({tag, "_host_ready"},   32'(bus.host_ready), 32'd0);
        check_eq({tag, "_select_bits"},  32'(bus.sse_select_bits), 32'd0);
        check_eq({tag, "_in_bits"},      32'(bus.sse_in_bits), 32'd0);
    endtask

    // rdy_mode: 0 always ready, 1 toggle, 2 random. out_mode: 0 random, 1 drain after 20 cycles.
    // kill_mode: 0 none, 1 abort, 2 async reset, triggered once kill_after pixels are forwarded.
    task automatic run_frame(input string name, input logic cam, input logic [6:0] sel,
                             input int n_junk, input logic fixed, input int rdy_mode,
                             input int out_mode, input int kill_mode, input int kill_after);
        logic [23:0] src_q[$];
        logic        sync_q[$];
        logic [23:0] exp_q[$];
        int sync_idx = 0;
        int ptr = 0, fwd = 0, outs = 0;
        int k_last_in = -1, k_last_out = -1;
        int done_cnt = 0, done_k = -1;
        int stall_err = 0, xsrc_err = 0, sel_err = 0, busy_err = 0;
        int exp_done;
        logic killed = 1'b0;

        // Source stream: junk (camera only), then the frame, then two spare pixels
        if (cam) begin
            for (int i = 0; i < n_junk; i++) begin
                src_q.push_back(24'($urandom));
                sync_q.push_back(1'b0);
            end
            sync_idx = n_junk;
            src_q.push_back(fixed ? 24'hAA0000 : 24'($urandom));
            sync_q.push_back(1'b1);
            for (int i = 1; i < FRAME + 2; i++) begin
                src_q.push_back(24'($urandom));
                sync_q.push_back(1'($urandom_range(1, 0)));
            end
        end else begin
            for (int i = 0; i < FRAME + 2; i++) begin
                src_q.push_back((fixed && i < FRAME) ? 24'(i + 1) : 24'($urandom));
                sync_q.push_back(1'b0);
            end
        end
        for (int i = 0; i < FRAME; i++) exp_q.push_back(src_q[sync_idx + i]);

        for (int k = 0; k < MAX_CYC; k++) begin
            logic in_fire, src_fire, other_rdy, real_fire, junk_fire, src_v;
            logic [23:0] px;
            logic        px_sync;
            @(negedge clk);
            if (bus.sse_select_valid && (bus.sse_select_bits !== {1'b0, sel})) sel_err++;
            if (frame_done) begin
                done_cnt++;
                if (done_k < 0) done_k = k;
            end
            if (k == 1) begin
                check_eq({name, "_busy_after_cmd"},   32'(busy), 32'd1);
                check_eq({name, "_select_after_cmd"}, 32'(bus.sse_select_valid), 32'd1);
                check_eq({name, "_eof_cleared"},      32'(out_eof), 32'd0);
            end
            if (done_k >= 0 && k == done_k + 1) begin
                check_eq({name, "_done_single"},  32'(frame_done), 32'd0);
                check_eq({name, "_busy_fall"},    32'(busy), 32'd0);
                check_eq({name, "_eof_set"},      32'(out_eof), 32'd1);
                check_eq({name, "_cmd_ready_back"}, 32'(bus.cmd_ready), 32'd1);
                break;
            end
            if (killed) begin
                check_eq({name, "_abort_busy"},     32'(busy), 32'd0);
                check_eq({name, "_abort_eof"},      32'(out_eof), 32'd0);
                check_eq({name, "_abort_in_valid"}, 32'(bus.sse_in_valid), 32'd0);
                break;
            end
            if (out_mode == 1 && k_last_in >= 0 && !busy) busy_err++;

            bus.cmd_valid        = (k == 0);
            bus.cmd_bits         = {cam, sel};
            bus.sse_select_ready = 1'($urandom_range(1, 0));
            src_v   = (ptr < src_q.size()) && ($urandom_range(3, 0) != 0);
            px      = (ptr < src_q.size()) ? src_q[ptr] : 24'h0;
            px_sync = (ptr < sync_q.size()) ? sync_q[ptr] : 1'b0;
            if (cam) begin
                bus.cam_valid  = src_v;
                bus.cam_bits   = px;
                bus.cam_sync   = px_sync;
                bus.host_valid = 1'($urandom_range(1, 0));
                bus.host_bits  = 24'($urandom);
            end else begin
                bus.host_valid = src_v;
                bus.host_bits  = px;
                bus.cam_valid  = 1'($urandom_range(1, 0));
                bus.cam_bits   = 24'($urandom);
                bus.cam_sync   = 1'($urandom_range(1, 0));
            end
            case (rdy_mode)
                0:       bus.sse_in_ready = 1'b1;
                1:       bus.sse_in_ready = 1'(k % 2);
                default: bus.sse_in_ready = 1'($urandom_range(1, 0));
            endcase
            if (kill_mode == 1 && fwd == kill_after) begin
                abort  = 1'b1;
                killed = 1'b1;
            end
            if (kill_mode == 2 && fwd == kill_after) begin
                if (cam) bus.cam_valid = 1'b1;
                else     bus.host_valid = 1'b1;
                bus.sse_in_ready = 1'b1;
                #1;
                check_eq({name, "_in_valid_before_reset"}, 32'(bus.sse_in_valid), 32'd1);
                #1 reset_n = 1'b0;
                #1;
                check_reset_outputs({name, "_async"});
                idle_inputs();
                return;
            end
            #1;
            in_fire   = bus.sse_in_valid & bus.sse_in_ready;
            src_fire  = cam ? (bus.cam_valid & bus.cam_ready) : (bus.host_valid & bus.host_ready);
            other_rdy = cam ? bus.host_ready : bus.cam_ready;
            if (other_rdy) xsrc_err++;
            if (ptr >= sync_idx && src_fire != in_fire) stall_err++;
            if (in_fire && !killed) begin
                if (fwd < FRAME)
                    check_eq($sformatf("%s_pixel%0d", name, fwd), 32'(bus.sse_in_bits), 32'(exp_q[fwd]));
                fwd++;
                k_last_in = k;
            end
            if (src_fire) ptr++;

            // SSE output model: never more outputs than accepted inputs
            if (out_mode == 0)
                real_fire = (outs < fwd) && (fwd > 0) && ($urandom_range(1, 0) != 0);
            else
                real_fire = (fwd == FRAME) && (outs < FRAME) && (k >= k_last_in + 20);
            junk_fire = (k == 0 || bus.sse_select_valid) && ($urandom_range(1, 0) != 0);
            if (real_fire) begin
                outs++;
                k_last_out = k;
            end
            bus.sse_out_fire = real_fire | junk_fire;
        end
        idle_inputs();

        if (kill_mode == 0) begin
            exp_done = ((k_last_in > k_last_out) ? k_last_in : k_last_out) + 1;
            check_eq({name, "_done_count"},   32'(done_cnt), 32'd1);
            check_eq({name, "_done_cycle"},   32'(done_k), 32'(exp_done));
            check_eq({name, "_forwarded"},    32'(fwd), 32'(FRAME));
            check_eq({name, "_consumed"},     32'(ptr), 32'(sync_idx + FRAME));
            check_eq({name, "_stall"},        32'(stall_err), 32'd0);
            check_eq({name, "_other_ready"},  32'(xsrc_err), 32'd0);
            check_eq({name, "_select_bits"},  32'(sel_err), 32'd0);
            if (out_mode == 1) check_eq({name, "_busy_drain"}, 32'(busy_err), 32'd0);
        end
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        run_frame("host05",      1'b0, 7'h05, 0, 1'b1, 0, 0, 0, 0);
        run_frame("cam_sync",    1'b1, 7'h03, 3, 1'b1, 0, 0, 0, 0);
        run_frame("host_bp",     1'b0, 7'($urandom), 0, 1'b0, 1, 0, 0, 0);
        run_frame("cam_bp",      1'b1, 7'($urandom), 2, 1'b0, 1, 0, 0, 0);
        run_frame("drain",       1'b0, 7'($urandom), 0, 1'b0, 0, 1, 0, 0);
        run_frame("abort_host",  1'b0, 7'($urandom), 0, 1'b0, 0, 0, 1, 3);
        run_frame("after_abort", 1'b0, 7'($urandom), 0, 1'b0, 2, 0, 0, 0);
        run_frame("abort_cam",   1'b1, 7'($urandom), 2, 1'b0, 2, 0, 1, 3);
        run_frame("after_abort_cam", 1'b1, 7'($urandom), 1, 1'b0, 2, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_frame($sformatf("rand%0d", i), 1'($urandom_range(1, 0)), 7'($urandom),
                      int'($urandom_range(4, 0)), 1'b0, 2, int'($urandom_range(1, 0)), 0, 0);
        end
        run_frame("reset_mid", 1'b0, 7'($urandom), 0, 1'b0, 0, 0, 2, 3);
        repeat (2) @(negedge clk);
        check_reset_outputs("reset_held");
        reset_n = 1'b1;
        run_frame("after_reset", 1'b1, 7'($urandom), 2, 1'b0, 2, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
